// File: rtl/regfile_wb_queue_pkg.sv
// Shared register-file constants and queue update encoding for the writeback queue slice.
package regfile_wb_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // Encoding equals {pop, push} so the helper below is a plain cast.
  typedef enum logic [1:0] {
    Q_HOLD = 2'b00,
    Q_PUSH = 2'b01,
    Q_POP  = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    return q_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Writeback request handshake between execute/memory sources and the writeback queue.
interface regfile_wb_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_rd, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rd, input in_data, output in_ready);
endinterface

// File: rtl/wbq_match.sv
// Bypass lookup: compares every queue entry against one read address and returns the
// data of the youngest valid match (the entry closest behind wr_ptr).
module wbq_match
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [PTR_W-1:0]             wr_ptr,
  input  logic [ADDR_W-1:0]            addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  logic [PTR_W-1:0] idx;

  // Walk from the oldest slot (wr_ptr) to the youngest so later matches override earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (addr != ADDR_W'(REG_ZERO)) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = wr_ptr + PTR_W'(i);
        if (ent_valid[idx] && (ent_rd[idx] == addr)) begin
          hit  = 1'b1;
          data = ent_data[idx];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register-file write port: FIFO buffering, one retire
// per cycle from the head, and two youngest-match bypass ports for the readers.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstb,
  regfile_wb_queue_if.slave  wb,
  input  logic               wr_stall,
  output logic               RegWr,
  output logic [ADDR_W-1:0]  Rw,
  output logic [DATA_W-1:0]  busW,
  input  logic [ADDR_W-1:0]  qa_addr,
  output logic               qa_hit,
  output logic [DATA_W-1:0]  qa_data,
  input  logic [ADDR_W-1:0]  qb_addr,
  output logic               qb_hit,
  output logic [DATA_W-1:0]  qb_data,
  output logic [CNT_W-1:0]   count
);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic                         store;
  logic                         pop;

  always_comb begin
    wb.in_ready = rstb && (count < CNT_W'(DEPTH));
    // Writes to r0 complete the handshake but never occupy a slot.
    store = wb.in_valid && wb.in_ready && (wb.in_rd != ADDR_W'(REG_ZERO));
    RegWr = (count != '0) && !wr_stall;
    pop   = RegWr;
    Rw    = RegWr ? rd_q[rd_ptr]   : '0;
    busW  = RegWr ? data_q[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (store) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case (q_op(store, pop))
        Q_PUSH:  count <= count + CNT_W'(1);
        Q_POP:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      rd_q[wr_ptr]   <= wb.in_rd;
      data_q[wr_ptr] <= wb.in_data;
    end
  end

  wbq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_a (
    .ent_valid (valid_q),
    .ent_rd    (rd_q),
    .ent_data  (data_q),
    .wr_ptr    (wr_ptr),
    .addr      (qa_addr),
    .hit       (qa_hit),
    .data      (qa_data)
  );

  wbq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_b (
    .ent_valid (valid_q),
    .ent_rd    (rd_q),
    .ent_data  (data_q),
    .wr_ptr    (wr_ptr),
    .addr      (qb_addr),
    .hit       (qb_hit),
    .data      (qb_data)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a small register-file model fed by RegWr.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rstb;
  logic        wr_stall;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic [4:0]  qa_addr, qb_addr;
  logic        qa_hit, qb_hit;
  logic [31:0] qa_data, qb_data;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [32];
  logic [4:0]  wlog_rd [64];
  logic [31:0] wlog_data [64];
  int          wcnt = 0;

  regfile_wb_queue_if #(.ADDR_W(5), .DATA_W(32)) wbif ();

  regfile_wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .wb       (wbif.slave),
    .wr_stall (wr_stall),
    .RegWr    (RegWr),
    .Rw       (Rw),
    .busW     (busW),
    .qa_addr  (qa_addr),
    .qa_hit   (qa_hit),
    .qa_data  (qa_data),
    .qb_addr  (qb_addr),
    .qb_hit   (qb_hit),
    .qb_data  (qb_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (RegWr) begin
      rf[Rw]          <= busW;
      wlog_rd[wcnt]   <= Rw;
      wlog_data[wcnt] <= busW;
      wcnt            <= wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wbif.in_valid = 1'b1;
    wbif.in_rd    = rd;
    wbif.in_data  = data;
    @(posedge clk);
    #1;
    wbif.in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [4:0]  exp_rd [4];
  logic [31:0] exp_dat [4];

  initial begin
    exp_rd[0] = 5'd17; exp_dat[0] = 32'hff17;
    exp_rd[1] = 5'd31; exp_dat[1] = 32'hff31;
    exp_rd[2] = 5'd5;  exp_dat[2] = 32'hff05;
    exp_rd[3] = 5'd9;  exp_dat[3] = 32'hff09;

    rstb = 1'b0; wr_stall = 1'b0; qa_addr = '0; qb_addr = '0;
    wbif.in_valid = 1'b0; wbif.in_rd = '0; wbif.in_data = '0;

    // 1: reset
    tick();
    rstb = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", wbif.in_ready, 1);
    chk("rst_regwr", RegWr, 0);
    chk("rst_rw", Rw, 0);
    chk("rst_busw", busW, 0);
    chk("rst_qa_hit", qa_hit, 0);
    chk("rst_qa_data", qa_data, 0);

    // 2: single push, retire next cycle
    push(5'd23, 32'hff23);
    qa_addr = 5'd23;
    #1;
    chk("single_regwr", RegWr, 1);
    chk("single_rw", Rw, 23);
    chk("single_busw", busW, 32'hff23);
    chk("single_count", count, 1);
    chk("single_head_hit", qa_hit, 1);
    chk("single_head_data", qa_data, 32'hff23);
    tick();
    chk("single_drained", count, 0);
    chk("single_regwr_off", RegWr, 0);
    chk("single_rf23", rf[23], 32'hff23);
    chk("single_wcnt", wcnt, 1);

    // 3: fill under stall, blocked 5th push, ordered drain
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(exp_rd[i], exp_dat[i]);
    #1;
    chk("full_count", count, 4);
    chk("full_ready", wbif.in_ready, 0);
    chk("full_regwr", RegWr, 0);
    qa_addr = 5'd9;
    #1;
    chk("full_bypass_hit", qa_hit, 1);
    chk("full_bypass_data", qa_data, 32'hff09);
    push(5'd3, 32'hff03);
    chk("full_held_count", count, 4);
    wr_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_regwr", RegWr, 1);
      chk("drain_rw", Rw, exp_rd[i]);
      chk("drain_busw", busW, exp_dat[i]);
      tick();
    end
    chk("drain_empty", count, 0);
    chk("drain_wcnt", wcnt, 5);
    chk("drain_rf31", rf[31], 32'hff31);

    // 4: youngest-match bypass
    wr_stall = 1'b1;
    push(5'd17, 32'd1);
    push(5'd17, 32'd2);
    qa_addr = 5'd17; qb_addr = 5'd0;
    #1;
    chk("byp_a_hit", qa_hit, 1);
    chk("byp_a_data", qa_data, 2);
    chk("byp_b_hit", qb_hit, 0);
    chk("byp_b_data", qb_data, 0);
    qb_addr = 5'd18;
    #1;
    chk("byp_miss_hit", qb_hit, 0);
    wr_stall = 1'b0;
    tick();
    chk("byp_after_pop_data", qa_data, 2);
    tick();
    chk("byp_empty_hit", qa_hit, 0);
    chk("byp_wcnt", wcnt, 7);
    chk("byp_rf17", rf[17], 2);

    // 5: write to r0 is swallowed
    chk("r0_ready", wbif.in_ready, 1);
    push(5'd0, 32'hff00);
    chk("r0_count", count, 0);
    chk("r0_regwr", RegWr, 0);
    tick();
    tick();
    chk("r0_wcnt", wcnt, 7);

    // 6: reset drops pending entries
    wr_stall = 1'b1;
    wbif.in_valid = 1'b1; wbif.in_rd = 5'd1; wbif.in_data = 32'haa1;
    qa_addr = 5'd1;
    #1;
    chk("cur_cycle_excluded", qa_hit, 0);
    push(5'd1, 32'haa1);
    push(5'd2, 32'haa2);
    push(5'd3, 32'haa3);
    chk("pre_rst_count", count, 3);
    rstb = 1'b0;
    #1;
    chk("in_rst_ready", wbif.in_ready, 0);
    tick();
    rstb = 1'b1;
    qa_addr = 5'd3;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_regwr", RegWr, 0);
    chk("mid_rst_qa_hit", qa_hit, 0);
    wr_stall = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_rst_wcnt", wcnt, 7);
    chk("mid_rst_regwr_late", RegWr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
